// File: rtl/accum_store_ctrl.sv
// Store-pass sequencer: streams ACCUM rows 0..rows-1 into OUT_MEM at row*stride + tile_col,
// then clears the accumulator. Addresses are built incrementally and the write path trails reads.
module accum_store_ctrl #(
   parameter int unsigned SYS_COL    = 16,
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned ACCUM_SIZE = 1024,
   parameter int unsigned RD_LAT     = 1,
   localparam int unsigned ACCUM_ROW = ACCUM_SIZE / SYS_COL,
   localparam int unsigned RW        = $clog2(ACCUM_ROW)
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] num_out,
   input  logic [DATA_WIDTH-1:0] tile_col,
   input  logic [RW:0]           num_rows,
   input  logic                  hold,
   output logic [SYS_COL-1:0]    accum_rd_en,
   output logic [RW-1:0]         accum_rd_addr,
   output logic [SYS_COL-1:0]    out_wr_en,
   output logic [ADDR_WIDTH-1:0] out_wr_addr,
   output logic                  accum_clr,
   output logic                  busy,
   output logic                  done,
   output logic                  cfg_err
);

   localparam int unsigned Shift   = $clog2(SYS_COL);
   localparam logic [RW:0] MaxRows = (RW+1)'(ACCUM_ROW);

   typedef enum logic [1:0] {StIdle, StIssue, StDrain, StClear} state_e;

   state_e                state_q, state_d;
   logic [RW-1:0]         row_q, row_d;
   logic [RW:0]           rows_q, rows_d;
   logic [ADDR_WIDTH-1:0] stride_q, stride_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [RD_LAT-1:0]     vld_q, vld_d;
   logic [ADDR_WIDTH-1:0] paddr_q [RD_LAT];
   logic [ADDR_WIDTH-1:0] paddr_d [RD_LAT];
   logic                  done_q, done_d;
   logic                  clr_q, clr_d;
   logic                  err_q, err_d;
   logic                  busy_q, busy_d;

   logic                  issue;
   logic                  pending;
   logic [DATA_WIDTH-1:0] stride_full;
   logic [RW:0]           rows_clamped;

   assign issue        = (state_q == StIssue) && !hold;
   assign stride_full  = num_out >> Shift;
   assign rows_clamped = (num_rows > MaxRows) ? MaxRows : num_rows;

   always_comb begin
      state_d  = state_q;
      row_d    = row_q;
      rows_d   = rows_q;
      stride_d = stride_q;
      addr_d   = addr_q;
      done_d   = 1'b0;
      clr_d    = 1'b0;
      err_d    = 1'b0;
      pending  = 1'b0;

      // Write pipe shifts every cycle; hold only gates what enters stage 0.
      vld_d[0]   = issue;
      paddr_d[0] = addr_q;
      for (int i = 1; i < int'(RD_LAT); i++) begin
         vld_d[i]   = vld_q[i-1];
         paddr_d[i] = paddr_q[i-1];
      end
      // Entries still short of the output stage after this cycle.
      for (int i = 0; i < int'(RD_LAT) - 1; i++) begin
         pending = pending | vld_q[i];
      end

      unique case (state_q)
         StIdle: begin
            if (start) begin
               if (stride_full == '0) begin
                  done_d = 1'b1;
                  err_d  = 1'b1;
               end else begin
                  rows_d   = rows_clamped;
                  stride_d = ADDR_WIDTH'(stride_full);
                  addr_d   = ADDR_WIDTH'(tile_col);
                  row_d    = '0;
                  if (rows_clamped == '0) begin
                     state_d = StClear;
                     clr_d   = 1'b1;
                     done_d  = 1'b1;
                  end else begin
                     state_d = StIssue;
                  end
               end
            end
         end
         StIssue: begin
            if (!hold) begin
               row_d  = row_q + RW'(1);
               addr_d = addr_q + stride_q;
               if ({1'b0, row_q} == rows_q - (RW+1)'(1)) begin
                  state_d = StDrain;
               end
            end
         end
         StDrain: begin
            if (!pending) begin
               state_d = StClear;
               clr_d   = 1'b1;
               done_d  = 1'b1;
            end
         end
         StClear: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      busy_d = (state_d == StIssue) || (state_d == StDrain);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= StIdle;
         row_q    <= '0;
         rows_q   <= '0;
         stride_q <= '0;
         addr_q   <= '0;
         vld_q    <= '0;
         paddr_q  <= '{default: '0};
         done_q   <= 1'b0;
         clr_q    <= 1'b0;
         err_q    <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         row_q    <= row_d;
         rows_q   <= rows_d;
         stride_q <= stride_d;
         addr_q   <= addr_d;
         vld_q    <= vld_d;
         paddr_q  <= paddr_d;
         done_q   <= done_d;
         clr_q    <= clr_d;
         err_q    <= err_d;
         busy_q   <= busy_d;
      end
   end

   assign accum_rd_en   = {SYS_COL{issue}};
   assign accum_rd_addr = issue ? row_q : '0;
   assign out_wr_en     = {SYS_COL{vld_q[RD_LAT-1]}};
   assign out_wr_addr   = vld_q[RD_LAT-1] ? paddr_q[RD_LAT-1] : '0;
   assign accum_clr     = clr_q;
   assign done          = done_q;
   assign cfg_err       = err_q;
   assign busy          = busy_q;

endmodule

// File: tb/tb_accum_store_ctrl.sv
// Directed bench for accum_store_ctrl: a default instance (RD_LAT=1, 16-bit addresses) and a
// second instance with RD_LAT=3 and 8-bit addresses for wrap and latency scenarios.
module tb_accum_store_ctrl;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Instance A: defaults
   logic        start = 1'b0, hold = 1'b0;
   logic [15:0] num_out = '0, tile_col = '0;
   logic [6:0]  num_rows = '0;
   logic [15:0] rd_en, wr_en, wr_addr;
   logic [5:0]  rd_addr;
   logic        clr, busy, done, err;

   // Instance B: ADDR_WIDTH=8, RD_LAT=3
   logic        b_start = 1'b0, b_hold = 1'b0;
   logic [15:0] b_num_out = '0, b_tile_col = '0;
   logic [6:0]  b_num_rows = '0;
   logic [15:0] b_rd_en, b_wr_en;
   logic [7:0]  b_wr_addr;
   logic [5:0]  b_rd_addr;
   logic        b_clr, b_busy, b_done, b_err;

   accum_store_ctrl dut (
      .clk(clk), .rstn(rstn), .start(start), .num_out(num_out), .tile_col(tile_col),
      .num_rows(num_rows), .hold(hold), .accum_rd_en(rd_en), .accum_rd_addr(rd_addr),
      .out_wr_en(wr_en), .out_wr_addr(wr_addr), .accum_clr(clr), .busy(busy), .done(done),
      .cfg_err(err)
   );

   accum_store_ctrl #(.ADDR_WIDTH(8), .RD_LAT(3)) dut_b (
      .clk(clk), .rstn(rstn), .start(b_start), .num_out(b_num_out), .tile_col(b_tile_col),
      .num_rows(b_num_rows), .hold(b_hold), .accum_rd_en(b_rd_en), .accum_rd_addr(b_rd_addr),
      .out_wr_en(b_wr_en), .out_wr_addr(b_wr_addr), .accum_clr(b_clr), .busy(b_busy),
      .done(b_done), .cfg_err(b_err)
   );

   int checks = 0, errors = 0;

   int wr_cyc[$], wr_adr[$], rd_cyc[$], rd_adr[$];
   int clr_cnt, done_cnt, overlap_cnt, split_cnt;
   int bwr_cyc[$], bwr_adr[$], brd_cyc[$];

   always @(negedge clk) begin
      if (wr_en == '1) begin wr_cyc.push_back(cyc); wr_adr.push_back(int'(wr_addr)); end
      else if (wr_en != '0) split_cnt++;
      if (rd_en == '1) begin rd_cyc.push_back(cyc); rd_adr.push_back(int'(rd_addr)); end
      else if (rd_en != '0) split_cnt++;
      if (clr) clr_cnt++;
      if (done) done_cnt++;
      if (clr && rd_en != '0) overlap_cnt++;
      if (b_wr_en == '1) begin bwr_cyc.push_back(cyc); bwr_adr.push_back(int'(b_wr_addr)); end
      if (b_rd_en == '1) brd_cyc.push_back(cyc);
   end

   task automatic clear_mon();
      wr_cyc.delete(); wr_adr.delete(); rd_cyc.delete(); rd_adr.delete();
      bwr_cyc.delete(); bwr_adr.delete(); brd_cyc.delete();
      clr_cnt = 0; done_cnt = 0; overlap_cnt = 0; split_cnt = 0;
   endtask

   // Start is high for cycle s; returns at the negedge of cycle s+1.
   task automatic pulse_start(input int no, input int tc, input int nr, output int s);
      @(negedge clk);
      num_out = no[15:0]; tile_col = tc[15:0]; num_rows = nr[6:0]; start = 1'b1;
      s = cyc;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Leaves time at the negedge of the done cycle; d = -1 on timeout.
   task automatic wait_done(input int max, output int d, output logic e);
      d = -1; e = 1'b0;
      for (int n = 0; n < max; n++) begin
         if (done) begin d = cyc; e = err; break; end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if ({rd_en, wr_en, wr_addr, rd_addr, clr, busy, done, err} !== '0) begin
         errors++; $display("FAIL reset_outputs_a: got %h expected 0",
                            {rd_en, wr_en, wr_addr, rd_addr, clr, busy, done, err});
      end
      checks++;
      if ({b_rd_en, b_wr_en, b_wr_addr, b_rd_addr, b_clr, b_busy, b_done, b_err} !== '0) begin
         errors++; $display("FAIL reset_outputs_b: got %h expected 0",
                            {b_rd_en, b_wr_en, b_wr_addr, b_rd_addr, b_clr, b_busy, b_done, b_err});
      end
      @(negedge clk); rstn = 1'b1;
      clear_mon();
      repeat (4) @(negedge clk);
      checks++;
      if (done_cnt + clr_cnt + wr_cyc.size() !== 0) begin
         errors++; $display("FAIL idle_after_reset: got %0d events expected 0",
                            done_cnt + clr_cnt + wr_cyc.size());
      end
   endtask

   task automatic test_basic();
      int s, d, bad; logic e;
      clear_mon();
      pulse_start(64, 2, 64, s);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL busy_after_start: got %b expected 1", busy); end
      wait_done(200, d, e);
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL busy_at_done: got %b expected 0", busy); end
      @(negedge clk);
      checks++;
      if (d !== s + 66) begin errors++; $display("FAIL basic_done_cycle: got %0d expected %0d", d - s, 66); end
      checks++;
      if (e !== 1'b0) begin errors++; $display("FAIL basic_cfg_err: got %b expected 0", e); end
      checks++;
      if (wr_cyc.size() !== 64) begin errors++; $display("FAIL basic_wr_count: got %0d expected 64", wr_cyc.size()); end
      bad = 0;
      for (int i = 0; i < wr_adr.size(); i++)
         if (wr_adr[i] !== 2 + 4*i || wr_cyc[i] !== s + 2 + i) bad++;
      checks++;
      if (bad !== 0) begin errors++; $display("FAIL basic_wr_addr_time: got %0d bad expected 0", bad); end
      bad = 0;
      for (int i = 0; i < rd_adr.size(); i++)
         if (rd_adr[i] !== i || rd_cyc[i] !== s + 1 + i) bad++;
      checks++;
      if (bad !== 0 || rd_adr.size() !== 64) begin
         errors++; $display("FAIL basic_reads: got %0d bad of %0d expected 0 of 64", bad, rd_adr.size());
      end
      checks++;
      if (clr_cnt !== 1) begin errors++; $display("FAIL basic_clr_count: got %0d expected 1", clr_cnt); end
      checks++;
      if (overlap_cnt + split_cnt !== 0) begin
         errors++; $display("FAIL basic_rd_clr_overlap: got %0d expected 0", overlap_cnt + split_cnt);
      end
   endtask

   task automatic test_hold();
      int s, d, bad; logic e;
      clear_mon();
      pulse_start(64, 2, 64, s);
      repeat (10) @(negedge clk);
      hold = 1'b1;
      repeat (5) @(negedge clk);
      hold = 1'b0;
      wait_done(200, d, e);
      @(negedge clk);
      checks++;
      if (d !== s + 71) begin errors++; $display("FAIL hold_done_cycle: got %0d expected %0d", d - s, 71); end
      checks++;
      if (wr_cyc.size() !== 64 || rd_adr.size() !== 64) begin
         errors++; $display("FAIL hold_counts: got %0d/%0d expected 64/64", wr_cyc.size(), rd_adr.size());
      end
      bad = 0;
      for (int i = 0; i < wr_adr.size(); i++)
         if (wr_adr[i] !== 2 + 4*i || wr_cyc[i] !== s + 2 + i + ((i >= 10) ? 5 : 0)) bad++;
      for (int i = 0; i < rd_adr.size(); i++)
         if (rd_adr[i] !== i) bad++;
      checks++;
      if (bad !== 0) begin errors++; $display("FAIL hold_sequence: got %0d bad expected 0", bad); end
   endtask

   task automatic test_rows_zero();
      int s, d; logic e;
      clear_mon();
      pulse_start(64, 2, 0, s);
      wait_done(20, d, e);
      @(negedge clk);
      checks++;
      if (d !== s + 1) begin errors++; $display("FAIL rows0_done_cycle: got %0d expected 1", d - s); end
      checks++;
      if (clr_cnt !== 1 || wr_cyc.size() !== 0 || rd_cyc.size() !== 0) begin
         errors++; $display("FAIL rows0_activity: got clr %0d wr %0d rd %0d expected 1 0 0",
                            clr_cnt, wr_cyc.size(), rd_cyc.size());
      end
   endtask

   task automatic test_rows_over();
      int s, d; logic e;
      clear_mon();
      pulse_start(64, 2, 69, s);
      wait_done(200, d, e);
      @(negedge clk);
      checks++;
      if (wr_cyc.size() !== 64) begin errors++; $display("FAIL rows_over_count: got %0d expected 64", wr_cyc.size()); end
      checks++;
      if (d !== s + 66) begin errors++; $display("FAIL rows_over_done: got %0d expected 66", d - s); end
   endtask

   task automatic test_cfg_err();
      int s, d; logic e;
      clear_mon();
      pulse_start(8, 2, 64, s);
      wait_done(20, d, e);
      @(negedge clk);
      checks++;
      if (d !== s + 1 || e !== 1'b1) begin
         errors++; $display("FAIL cfg_err_pulse: got done@%0d err %b expected done@1 err 1", d - s, e);
      end
      checks++;
      if (wr_cyc.size() + rd_cyc.size() + clr_cnt !== 0) begin
         errors++; $display("FAIL cfg_err_activity: got %0d expected 0",
                            wr_cyc.size() + rd_cyc.size() + clr_cnt);
      end
   endtask

   task automatic test_back_to_back();
      int s, s2, d, bad; logic e;
      clear_mon();
      pulse_start(64, 2, 64, s);
      repeat (3) @(negedge clk);
      pulse_start(16, 100, 3, s2);
      wait_done(200, d, e);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      checks++;
      if (d !== s + 66) begin errors++; $display("FAIL b2b_done_cycle: got %0d expected 66", d - s); end
      bad = 0;
      for (int i = 0; i < wr_adr.size(); i++) if (wr_adr[i] !== 2 + 4*i) bad++;
      checks++;
      if (bad !== 0 || wr_adr.size() !== 64) begin
         errors++; $display("FAIL b2b_writes: got %0d bad of %0d expected 0 of 64", bad, wr_adr.size());
      end
      checks++;
      if (done_cnt !== 1 || clr_cnt !== 1) begin
         errors++; $display("FAIL b2b_ignored_starts: got done %0d clr %0d expected 1 1", done_cnt, clr_cnt);
      end
   endtask

   task automatic test_reset_mid();
      int s, d; logic e;
      clear_mon();
      pulse_start(64, 2, 64, s);
      repeat (18) @(negedge clk);
      checks++;
      if (rd_en !== '1) begin errors++; $display("FAIL mid_issue_active: got %h expected ffff", rd_en); end
      rstn = 1'b0;
      #1;
      checks++;
      if ({rd_en, wr_en, wr_addr, clr, busy, done, err} !== '0) begin
         errors++; $display("FAIL mid_reset_outputs: got %h expected 0",
                            {rd_en, wr_en, wr_addr, clr, busy, done, err});
      end
      repeat (3) @(negedge clk);
      checks++;
      if (clr_cnt + done_cnt !== 0) begin
         errors++; $display("FAIL mid_reset_no_done: got %0d expected 0", clr_cnt + done_cnt);
      end
      rstn = 1'b1;
      clear_mon();
      pulse_start(64, 6, 64, s);
      wait_done(200, d, e);
      @(negedge clk);
      checks++;
      if (d !== s + 66 || wr_adr.size() !== 64 || clr_cnt !== 1) begin
         errors++; $display("FAIL restart_pass: got done %0d wr %0d clr %0d expected 66 64 1",
                            d - s, wr_adr.size(), clr_cnt);
      end
      checks++;
      if (wr_adr.size() == 0 || wr_adr[0] !== 6) begin
         errors++; $display("FAIL restart_first_addr: got %0d expected 6",
                            (wr_adr.size() == 0) ? -1 : wr_adr[0]);
      end
   endtask

   task automatic test_wrap_lat3();
      int s, d, bad;
      int exp_a[4] = '{250, 254, 2, 6};
      clear_mon();
      @(negedge clk);
      b_num_out = 16'd64; b_tile_col = 16'd250; b_num_rows = 7'd4; b_start = 1'b1;
      s = cyc;
      @(negedge clk);
      b_start = 1'b0;
      d = -1;
      for (int n = 0; n < 50; n++) begin
         if (b_done) begin d = cyc; break; end
         @(negedge clk);
      end
      @(negedge clk);
      checks++;
      if (d !== s + 8) begin errors++; $display("FAIL lat3_done_cycle: got %0d expected 8", d - s); end
      checks++;
      if (bwr_adr.size() !== 4 || brd_cyc.size() !== 4) begin
         errors++; $display("FAIL lat3_counts: got %0d/%0d expected 4/4", bwr_adr.size(), brd_cyc.size());
      end
      bad = 0;
      for (int i = 0; i < bwr_adr.size() && i < 4; i++) if (bwr_adr[i] !== exp_a[i]) bad++;
      checks++;
      if (bad !== 0) begin errors++; $display("FAIL wrap_addrs: got %0d bad expected 0", bad); end
      bad = 0;
      for (int i = 0; i < bwr_cyc.size() && i < brd_cyc.size(); i++)
         if (bwr_cyc[i] !== brd_cyc[i] + 3 || brd_cyc[i] !== s + 1 + i) bad++;
      checks++;
      if (bad !== 0) begin errors++; $display("FAIL lat3_trail: got %0d bad expected 0", bad); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_hold();
      test_rows_zero();
      test_rows_over();
      test_cfg_err();
      test_back_to_back();
      test_reset_mid();
      test_wrap_lat3();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
